// File: rtl/sextium_seq_ctrl.sv
// sextium_seq_ctrl: successor sequencer for the Sextium III datapath.
// Fetches an instruction word, then walks its 4-bit opcode slots one per
// decode step. It drives the datapath mux selects and write strobes, and it
// handles multi-cycle MUL/DIV waits, IO completion and a sticky illegal-opcode
// trap.
module sextium_seq_ctrl #(
  parameter int SLOT_BITS  = 2,
  parameter int DIV_CYCLES = 3,
  parameter int MUL_CYCLES = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           insn,
  input  logic                 accz,
  input  logic                 accn,
  input  logic                 iobusy,
  input  logic                 mem_ack,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 acc_write,
  output logic                 seladdr,
  output logic [1:0]           selacc,
  output logic                 selswap,
  output logic                 doswap,
  output logic                 selpc1,
  output logic                 selpc2,
  output logic [SLOT_BITS-1:0] curinsn,
  output logic [1:0]           aluinsn,
  output logic                 alu_start,
  output logic                 runio,
  output logic                 fault,
  output logic [2:0]           stateout
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_IOWAIT  = 3'd2,
    S_ALUWAIT = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  // What the state register does at the next clock edge.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_FETCH,
    ACT_DECODE0,
    ACT_IOWAIT,
    ACT_ALUWAIT,
    ACT_FAULT
  } action_t;

  state_t     state;
  action_t    action;
  logic [3:0] counter;
  logic [3:0] load_count;
  logic [1:0] alu_op;
  logic [1:0] alu_code;

  assign stateout = state;

  // Decode state/opcode into strobes, selects and the next-step action.
  // Reset forces every output low so nothing reaches the datapath during reset.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    acc_write  = 1'b0;
    seladdr    = 1'b0;
    selacc     = 2'd0;
    selswap    = 1'b0;
    doswap     = 1'b0;
    selpc1     = 1'b0;
    selpc2     = 1'b0;
    alu_start  = 1'b0;
    runio      = 1'b0;
    alu_code   = 2'd0;
    load_count = 4'd0;
    action     = ACT_HOLD;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = 1'b1;
        if (mem_ack) begin
          pc_write = 1'b1;
          action   = ACT_DECODE0;
        end
      end
      S_DECODE: begin
        case (insn)
          4'd0: action = ACT_ADVANCE;
          4'd1: begin
            runio  = 1'b1;
            selacc = 2'd1;
            action = ACT_IOWAIT;
          end
          4'd2: begin
            mem_read  = 1'b1;
            seladdr   = 1'b1;
            acc_write = mem_ack;
            if (mem_ack) action = ACT_ADVANCE;
          end
          4'd3: begin
            mem_write = 1'b1;
            seladdr   = 1'b1;
            if (mem_ack) action = ACT_ADVANCE;
          end
          4'd4, 4'd5: begin
            selacc    = 2'd2;
            acc_write = 1'b1;
            doswap    = 1'b1;
            selswap   = insn[0];
            action    = ACT_ADVANCE;
          end
          4'd6, 4'd7: begin
            if ((!insn[0] && accz) || (insn[0] && accn)) begin
              pc_write = 1'b1;
              selpc1   = 1'b1;
              action   = ACT_FETCH;
            end else begin
              action = ACT_ADVANCE;
            end
          end
          4'd8: begin
            pc_write = 1'b1;
            selpc1   = 1'b1;
            selpc2   = 1'b1;
            action   = ACT_FETCH;
          end
          4'd9: begin
            mem_read = 1'b1;
            if (mem_ack) begin
              acc_write = 1'b1;
              pc_write  = 1'b1;
              action    = ACT_ADVANCE;
            end
          end
          4'd10, 4'd11: begin
            alu_code  = {1'b0, insn[0]};
            selacc    = 2'd3;
            acc_write = 1'b1;
            action    = ACT_ADVANCE;
          end
          4'd12: begin
            alu_code = 2'd2;
            selacc   = 2'd3;
            if (MUL_CYCLES == 0) begin
              acc_write = 1'b1;
              action    = ACT_ADVANCE;
            end else begin
              alu_start  = 1'b1;
              load_count = 4'(MUL_CYCLES);
              action     = ACT_ALUWAIT;
            end
          end
          4'd13: begin
            alu_code   = 2'd3;
            selacc     = 2'd3;
            alu_start  = 1'b1;
            load_count = 4'(DIV_CYCLES);
            action     = ACT_ALUWAIT;
          end
          default: action = ACT_FAULT;
        endcase
      end
      S_IOWAIT: begin
        selacc = 2'd1;
        runio  = iobusy;
        if (!iobusy) begin
          acc_write = 1'b1;
          action    = ACT_ADVANCE;
        end
      end
      S_ALUWAIT: begin
        alu_code = alu_op;
        selacc   = 2'd3;
        if (counter == 4'd1) begin
          acc_write = 1'b1;
          action    = ACT_ADVANCE;
        end
      end
      default: action = ACT_HOLD;
    endcase
    aluinsn = alu_code;
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      acc_write = 1'b0;
      seladdr   = 1'b0;
      selacc    = 2'd0;
      selswap   = 1'b0;
      doswap    = 1'b0;
      selpc1    = 1'b0;
      selpc2    = 1'b0;
      alu_start = 1'b0;
      runio     = 1'b0;
      aluinsn   = 2'd0;
    end
  end

  // State, slot index, wait counter, latched ALU op and sticky fault flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      curinsn <= '0;
      counter <= 4'd0;
      alu_op  <= 2'd0;
      fault   <= 1'b0;
    end else begin
      if (state == S_ALUWAIT) counter <= counter - 1'b1;
      case (action)
        ACT_ADVANCE: begin
          if (&curinsn) begin
            state   <= S_FETCH;
            curinsn <= '0;
          end else begin
            state   <= S_DECODE;
            curinsn <= curinsn + 1'b1;
          end
        end
        ACT_FETCH: begin
          state   <= S_FETCH;
          curinsn <= '0;
        end
        ACT_DECODE0: begin
          state   <= S_DECODE;
          curinsn <= '0;
        end
        ACT_IOWAIT: state <= S_IOWAIT;
        ACT_ALUWAIT: begin
          state   <= S_ALUWAIT;
          counter <= load_count;
          alu_op  <= alu_code;
        end
        ACT_FAULT: begin
          state <= S_FAULT;
          fault <= 1'b1;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_sextium_seq_ctrl.sv
// tb_sextium_seq_ctrl: scoreboard bench for the Sextium III sequencer.
// A cycle-level reference model pushes the expected output vector for each
// cycle when the stimulus is driven. A negedge monitor pops the vector and
// compares it with the DUT outputs.
module tb_sextium_seq_ctrl;

  localparam int SLOT_BITS  = 2;
  localparam int DIV_CYCLES = 3;
  localparam int MUL_CYCLES = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] slot;
    logic       flt;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic       accw;
    logic       sa;
    logic [1:0] sacc;
    logic       ssw;
    logic       dsw;
    logic       sp1;
    logic       sp2;
    logic [1:0] alu;
    logic       ast;
    logic       rio;
  } outs_t;

  logic       clock;
  logic       reset;
  logic [3:0] insn;
  logic       accz, accn, iobusy, mem_ack;
  logic       mem_read, mem_write, ir_write, pc_write, acc_write, seladdr;
  logic [1:0] selacc;
  logic       selswap, doswap, selpc1, selpc2;
  logic [1:0] curinsn;
  logic [1:0] aluinsn;
  logic       alu_start, runio, fault;
  logic [2:0] stateout;
  logic [21:0] obs;

  int checks = 0;
  int errors = 0;

  outs_t exp_q[$];
  string tag_q[$];

  // Reference model state and the image of the instruction register.
  logic [2:0]  m_state;
  logic [1:0]  m_slot;
  logic [3:0]  m_cnt;
  logic [1:0]  m_op;
  logic        m_fault;
  logic [15:0] ir_word;

  sextium_seq_ctrl #(
    .SLOT_BITS (SLOT_BITS),
    .DIV_CYCLES(DIV_CYCLES),
    .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .insn     (insn),
    .accz     (accz),
    .accn     (accn),
    .iobusy   (iobusy),
    .mem_ack  (mem_ack),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .acc_write(acc_write),
    .seladdr  (seladdr),
    .selacc   (selacc),
    .selswap  (selswap),
    .doswap   (doswap),
    .selpc1   (selpc1),
    .selpc2   (selpc2),
    .curinsn  (curinsn),
    .aluinsn  (aluinsn),
    .alu_start(alu_start),
    .runio    (runio),
    .fault    (fault),
    .stateout (stateout)
  );

  assign obs = {stateout, curinsn, fault, mem_read, mem_write, ir_write, pc_write,
                acc_write, seladdr, selacc, selswap, doswap, selpc1, selpc2,
                aluinsn, alu_start, runio};

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [21:0] observed,
                             input logic [21:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Next {state, slot} after finishing the current slot.
  function automatic logic [4:0] nextSlot(input logic [1:0] slot);
    if (slot == 2'd3) return {3'd0, 2'd0};
    return {3'd1, slot + 2'd1};
  endfunction

  // Drive one cycle of inputs, predict that cycle's outputs, then step the model.
  task automatic applyStimulus(input string tag, input logic rst, input logic ack,
                               input logic busy, input logic z, input logic n);
    outs_t      e;
    logic [3:0] op;
    logic [2:0] n_state;
    logic [1:0] n_slot;
    logic [3:0] n_cnt;
    logic [1:0] n_op;
    logic       n_fault;
    op      = ir_word[{m_slot, 2'b00} +: 4];
    reset   = rst;
    mem_ack = ack;
    iobusy  = busy;
    accz    = z;
    accn    = n;
    insn    = op;
    e       = '0;
    e.st    = m_state;
    e.slot  = m_slot;
    e.flt   = m_fault;
    n_state = m_state;
    n_slot  = m_slot;
    n_cnt   = m_cnt;
    n_op    = m_op;
    n_fault = m_fault;
    if (rst) begin
      e       = '0;
      n_state = 3'd0;
      n_slot  = 2'd0;
      n_cnt   = 4'd0;
      n_op    = 2'd0;
      n_fault = 1'b0;
    end else if (m_state == 3'd0) begin
      e.mr  = 1'b1;
      e.irw = 1'b1;
      if (ack) begin
        e.pcw   = 1'b1;
        n_state = 3'd1;
        n_slot  = 2'd0;
      end
    end else if (m_state == 3'd1) begin
      case (op)
        4'd0: {n_state, n_slot} = nextSlot(m_slot);
        4'd1: begin e.rio = 1'b1; e.sacc = 2'd1; n_state = 3'd2; end
        4'd2: begin
          e.mr = 1'b1; e.sa = 1'b1; e.accw = ack;
          if (ack) {n_state, n_slot} = nextSlot(m_slot);
        end
        4'd3: begin
          e.mw = 1'b1; e.sa = 1'b1;
          if (ack) {n_state, n_slot} = nextSlot(m_slot);
        end
        4'd4, 4'd5: begin
          e.sacc = 2'd2; e.accw = 1'b1; e.dsw = 1'b1; e.ssw = (op == 4'd5);
          {n_state, n_slot} = nextSlot(m_slot);
        end
        4'd6, 4'd7: begin
          if ((op == 4'd6) ? z : n) begin
            e.pcw = 1'b1; e.sp1 = 1'b1; n_state = 3'd0; n_slot = 2'd0;
          end else begin
            {n_state, n_slot} = nextSlot(m_slot);
          end
        end
        4'd8: begin
          e.pcw = 1'b1; e.sp1 = 1'b1; e.sp2 = 1'b1; n_state = 3'd0; n_slot = 2'd0;
        end
        4'd9: begin
          e.mr = 1'b1;
          if (ack) begin
            e.accw = 1'b1; e.pcw = 1'b1;
            {n_state, n_slot} = nextSlot(m_slot);
          end
        end
        4'd10: begin e.alu = 2'd0; e.sacc = 2'd3; e.accw = 1'b1; {n_state, n_slot} = nextSlot(m_slot); end
        4'd11: begin e.alu = 2'd1; e.sacc = 2'd3; e.accw = 1'b1; {n_state, n_slot} = nextSlot(m_slot); end
        4'd12: begin e.alu = 2'd2; e.sacc = 2'd3; e.accw = 1'b1; {n_state, n_slot} = nextSlot(m_slot); end
        4'd13: begin
          e.alu = 2'd3; e.sacc = 2'd3; e.ast = 1'b1;
          n_cnt = 4'(DIV_CYCLES); n_op = 2'd3; n_state = 3'd3;
        end
        default: begin n_state = 3'd4; n_fault = 1'b1; end
      endcase
    end else if (m_state == 3'd2) begin
      e.sacc = 2'd1;
      e.rio  = busy;
      if (!busy) begin
        e.accw = 1'b1;
        {n_state, n_slot} = nextSlot(m_slot);
      end
    end else if (m_state == 3'd3) begin
      e.alu  = m_op;
      e.sacc = 2'd3;
      n_cnt  = m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        e.accw = 1'b1;
        {n_state, n_slot} = nextSlot(m_slot);
      end
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clock);
    m_state = n_state;
    m_slot  = n_slot;
    m_cnt   = n_cnt;
    m_op    = n_op;
    m_fault = n_fault;
    #1;
  endtask

  // Scoreboard monitor: compare DUT outputs mid-cycle against the oldest prediction.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      outs_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checkOutput(t, obs, e);
    end
  end

  // Stop a runaway simulation with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed program of instruction words and input patterns.
  initial begin
    reset   = 1'b1;
    insn    = 4'd0;
    accz    = 1'b0;
    accn    = 1'b0;
    iobusy  = 1'b0;
    mem_ack = 1'b0;
    ir_word = 16'h0000;
    m_state = 3'd0;
    m_slot  = 2'd0;
    m_cnt   = 4'd0;
    m_op    = 2'd0;
    m_fault = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus("reset_hold", 1, 1, 0, 0, 0);

    ir_word = 16'h0BA0;
    applyStimulus("fetch_add_sub", 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("word_nop_add_sub", 0, 0, 0, 0, 0);

    ir_word = 16'h000D;
    applyStimulus("fetch_div", 0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus("div_wait", 0, 0, 0, 0, 0);

    ir_word = 16'h0001;
    applyStimulus("fetch_sys", 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("sys_busy", 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("sys_done", 0, 0, 0, 0, 0);

    ir_word = 16'h0060;
    applyStimulus("fetch_brz", 0, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) applyStimulus("brz_taken", 0, 0, 0, 1, 0);
    applyStimulus("fetch_brz2", 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus("brz_not_taken", 0, 0, 0, 0, 0);

    ir_word = 16'h329C;
    applyStimulus("fetch_wait", 0, 0, 0, 0, 0);
    applyStimulus("fetch_ack", 0, 1, 0, 0, 0);
    applyStimulus("mul_single", 0, 0, 0, 0, 0);
    applyStimulus("const_wait", 0, 0, 0, 0, 0);
    applyStimulus("const_ack", 0, 1, 0, 0, 0);
    applyStimulus("load_wait", 0, 0, 0, 0, 0);
    applyStimulus("load_ack", 0, 1, 0, 0, 0);
    applyStimulus("store_wait", 0, 0, 0, 0, 0);
    applyStimulus("store_ack", 0, 1, 0, 0, 0);

    ir_word = 16'h0754;
    applyStimulus("fetch_swap", 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus("swap_brn", 0, 0, 0, 0, 1);

    ir_word = 16'h0008;
    applyStimulus("fetch_jump", 0, 1, 0, 0, 0);
    applyStimulus("jump", 0, 0, 0, 0, 0);

    ir_word = 16'h0001;
    applyStimulus("fetch_midreset", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("io_before_reset", 0, 0, 1, 0, 0);
    applyStimulus("reset_mid_io", 1, 1, 1, 0, 0);
    applyStimulus("fetch_after_reset", 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus("sys_quick", 0, 0, 0, 0, 0);

    ir_word = 16'h0F00;
    applyStimulus("fetch_fault", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("to_fault", 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus("fault_hold", 0, 1, 1, 1, 1);
    for (int i = 0; i < 2; i++) applyStimulus("fault_reset", 1, 1, 0, 0, 0);
    ir_word = 16'h0000;
    applyStimulus("resume_fetch", 0, 1, 0, 0, 0);
    applyStimulus("resume_decode", 0, 0, 0, 0, 0);

    @(negedge clock);
    #1;
    checkOutput("queue_drained", 22'(exp_q.size()), 22'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
